// File: rtl/tt_sweep_collector_pkg.sv
// Shared types and defaults for the truth-table sweep collector.
// Optional feature macro used by this slice: TT_POPCOUNT_EN.
package tt_pkg;

    localparam int unsigned NIN_DEF  = 7;
    localparam int unsigned TT_W_DEF = 128;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, HOLD} tt_state_e;

    typedef logic [TT_W_DEF-1:0] tt_t;

endpackage

// File: rtl/tt_sweep_collector_if.sv
// Bundle of the function-side and consumer-side signals of the sweep collector.
// TT_POPCOUNT_EN adds the popcount signal.
interface tt_sweep_collector_if #(
    parameter int unsigned NIN = tt_pkg::NIN_DEF
) ();

    localparam int unsigned TT_W = 2 ** NIN;

    logic            start;
    logic [NIN-1:0]  x;
    logic            f_out;
    logic            busy;
    logic [TT_W-1:0] tt;
    logic            tt_valid;
    logic            tt_ready;
`ifdef TT_POPCOUNT_EN
    logic [NIN:0]    popcount;
`endif

    modport master (
        input  start,
        input  f_out,
        input  tt_ready,
        output x,
        output busy,
        output tt,
        output tt_valid
`ifdef TT_POPCOUNT_EN
        ,
        output popcount
`endif
    );

    modport slave (
        output start,
        output f_out,
        output tt_ready,
        input  x,
        input  busy,
        input  tt,
        input  tt_valid
`ifdef TT_POPCOUNT_EN
        ,
        input  popcount
`endif
    );

endinterface

// File: rtl/tt_sweep_collector_sample_delay.sv
// Carries {valid, minterm index} alongside the function's pipeline so each sample lands
// on the right truth-table bit; a plain pass-through for a combinational function.
module tt_sample_delay #(
    parameter int unsigned LAT = 0,
    parameter int unsigned IW  = 7
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [IW-1:0] i_idx,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    if (LAT == 0) begin : g_pass
        assign o_valid = i_valid;
        assign o_idx   = i_idx;

        logic w_unused;
        assign w_unused = ^{i_clk, i_rst};
    end else begin : g_pipe
        logic [LAT-1:0] r_valid;
        logic [IW-1:0]  r_idx [LAT];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_valid <= '0;
            end else begin
                r_valid[0] <= i_valid;
                for (int i = 1; i < int'(LAT); i++) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
        end

        // Index needs no reset: it is only consumed when its valid bit is set.
        always_ff @(posedge i_clk) begin
            r_idx[0] <= i_idx;
            for (int i = 1; i < int'(LAT); i++) begin
                r_idx[i] <= r_idx[i-1];
            end
        end

        assign o_valid = r_valid[LAT-1];
        assign o_idx   = r_idx[LAT-1];
    end

endmodule

// File: rtl/tt_sweep_collector.sv
// Sweeps every minterm onto x, captures f_out into the truth table and offers it via tt_valid/tt_ready.
// Define TT_POPCOUNT_EN to add a running count of ones in the table.
module tt_sweep_collector
    import tt_pkg::*;
#(
    parameter int unsigned NIN = NIN_DEF,
    parameter int unsigned LAT = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    tt_sweep_collector_if.master io_bus
);

    localparam int unsigned TT_W     = 2 ** NIN;
    localparam int unsigned CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [NIN:0] LAST_IDX = (NIN + 1)'(TT_W - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(LAT - 1);

    tt_state_e        r_state;
    tt_state_e        w_state_d;
    logic [NIN:0]     r_idx;
    logic [CNT_W-1:0] r_drain;
    logic [TT_W-1:0]  r_tt;
    logic             w_smp_in_valid;
    logic             w_smp_valid;
    logic [NIN-1:0]   w_smp_idx;
`ifdef TT_POPCOUNT_EN
    logic [NIN:0]     r_pop;
`endif

    always_comb begin
        w_state_d      = r_state;
        io_bus.x       = '0;
        w_smp_in_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (io_bus.start) begin
                    w_state_d = SWEEP;
                end
            end
            SWEEP: begin
                io_bus.x       = r_idx[NIN-1:0];
                w_smp_in_valid = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_d = (LAT == 0) ? HOLD : DRAIN;
                end
            end
            DRAIN: begin
                // Keep the last minterm on x while the function pipeline empties.
                io_bus.x = '1;
                if (r_drain == LAST_DRAIN) begin
                    w_state_d = HOLD;
                end
            end
            HOLD: begin
                if (io_bus.tt_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    tt_sample_delay #(
        .LAT (LAT),
        .IW  (NIN)
    ) u_sample_delay (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (w_smp_in_valid),
        .i_idx   (r_idx[NIN-1:0]),
        .o_valid (w_smp_valid),
        .o_idx   (w_smp_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_drain <= '0;
            r_tt    <= '0;
`ifdef TT_POPCOUNT_EN
            r_pop   <= '0;
`endif
        end else begin
            r_state <= w_state_d;

            if (r_state == IDLE && io_bus.start) begin
                r_idx <= '0;
                r_tt  <= '0;
`ifdef TT_POPCOUNT_EN
                r_pop <= '0;
`endif
            end else if (r_state == SWEEP) begin
                r_idx <= r_idx + 1'b1;
            end

            if (r_state == DRAIN) begin
                r_drain <= r_drain + 1'b1;
            end else begin
                r_drain <= '0;
            end

            if (w_smp_valid) begin
                r_tt[w_smp_idx] <= io_bus.f_out;
`ifdef TT_POPCOUNT_EN
                r_pop <= r_pop + (NIN + 1)'(io_bus.f_out);
`endif
            end
        end
    end

    assign io_bus.busy     = (r_state == SWEEP) || (r_state == DRAIN);
    assign io_bus.tt_valid = (r_state == HOLD);
    assign io_bus.tt       = r_tt;
`ifdef TT_POPCOUNT_EN
    assign io_bus.popcount = r_pop;
`endif

endmodule
